// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage: NZCV flag layout and
// ARM-style condition-code encodings, reused by the issue stage.
package alu_result_stage_pkg;

    // Architectural flags packed as {N, Z, C, V}
    typedef logic [3:0] nzcv_t;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Build an NZCV value from its four individual flags
    function automatic nzcv_t make_nzcv(input logic n, input logic z,
                                        input logic c, input logic v);
        nzcv_t f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_result_stage_cond_eval.sv
// Pure combinational condition-code evaluator: NZCV + 4-bit code -> pass.
module alu_result_stage_cond_eval
    import alu_result_stage_pkg::*;
(
    input  logic [3:0] nzcv_i,
    input  logic [3:0] cond_i,
    output logic       pass_o
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = nzcv_i[FLAG_N];
    assign z = nzcv_i[FLAG_Z];
    assign c = nzcv_i[FLAG_C];
    assign v = nzcv_i[FLAG_V];

    // Decode the condition against the supplied flags
    always_comb begin
        pass_o = 1'b0;
        unique case (cond_i)
            COND_EQ: pass_o = z;
            COND_NE: pass_o = ~z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = ~c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = ~n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = ~v;
            COND_HI: pass_o = c & ~z;
            COND_LS: pass_o = ~c | z;
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = ~z & (n == v);
            COND_LE: pass_o = z | (n != v);
            COND_AL: pass_o = 1'b1;
            COND_NV: pass_o = 1'b0;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry skid buffer carrying {result, dest tag}, NZCV
// flag register committed on accept, and condition evaluation for issue.
// Optional build macro ALU_FLAGS_BYPASS_EN: cond_pass sees the flags being
// committed this cycle instead of waiting for them to land in flags_nzcv.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_carry,
    input  logic              in_overflow,
    input  logic              in_set_flags,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DEST_W-1:0] out_dest,
    output logic [3:0]        flags_nzcv,
    input  logic [3:0]        cond_code,
    output logic              cond_pass
);

    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic [DEST_W-1:0] head_dest_q, head_dest_d;
    logic [DATA_W-1:0] tail_data_q, tail_data_d;
    logic [DEST_W-1:0] tail_dest_q, tail_dest_d;
    nzcv_t             flags_q, flags_d;

    logic  accept;
    logic  deliver;
    nzcv_t new_flags;
    nzcv_t eval_flags;

    // Ready depends only on registered occupancy, never on out_ready
    assign in_ready   = (count_q != 2'd2);
    assign out_valid  = (count_q != 2'd0);
    assign out_data   = head_data_q;
    assign out_dest   = head_dest_q;
    assign flags_nzcv = flags_q;

    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;
    assign new_flags = make_nzcv(in_data[DATA_W-1], (in_data == '0), in_carry, in_overflow);

    // Skid-buffer next state: head is always the oldest beat
    always_comb begin
        count_d     = count_q;
        head_data_d = head_data_q;
        head_dest_d = head_dest_q;
        tail_data_d = tail_data_q;
        tail_dest_d = tail_dest_q;

        if (deliver) begin
            if (count_q == 2'd2) begin
                head_data_d = tail_data_q;
                head_dest_d = tail_dest_q;
                if (accept) begin
                    tail_data_d = in_data;
                    tail_dest_d = in_dest;
                end
            end else if (accept) begin
                // count 1: head leaves, incoming beat becomes the new head
                head_data_d = in_data;
                head_dest_d = in_dest;
            end
            if (!accept) begin
                count_d = count_q - 2'd1;
            end
        end else if (accept) begin
            if (count_q == 2'd0) begin
                head_data_d = in_data;
                head_dest_d = in_dest;
            end else begin
                tail_data_d = in_data;
                tail_dest_d = in_dest;
            end
            count_d = count_q + 2'd1;
        end
    end

    // Flags commit when a set-flags beat is accepted, independent of delivery
    always_comb begin
        flags_d = flags_q;
        if (accept && in_set_flags) begin
            flags_d = new_flags;
        end
    end

    // Flags used for condition evaluation
    always_comb begin
`ifdef ALU_FLAGS_BYPASS_EN
        eval_flags = (accept && in_set_flags) ? new_flags : flags_q;
`else
        eval_flags = flags_q;
`endif
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= 2'd0;
            head_data_q <= '0;
            head_dest_q <= '0;
            tail_data_q <= '0;
            tail_dest_q <= '0;
            flags_q     <= '0;
        end else begin
            count_q     <= count_d;
            head_data_q <= head_data_d;
            head_dest_q <= head_dest_d;
            tail_data_q <= tail_data_d;
            tail_dest_q <= tail_dest_d;
            flags_q     <= flags_d;
        end
    end

    alu_result_stage_cond_eval u_cond_eval (
        .nzcv_i (eval_flags),
        .cond_i (cond_code),
        .pass_o (cond_pass)
    );

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
Pipeline stage directly downstream of the 32-bit subtractor/ALU datapath. Registers the ALU result with its destination tag through a 2-entry skid buffer with valid/ready handshakes on both sides. Derives N/Z from the result and commits C/V from the ALU into an architectural NZCV flags register when the set-flags bit is high. Evaluates a 4-bit condition code against the flags for the issue stage.

Parameters:
DATA_W, 32, result width; N is bit DATA_W-1.
DEST_W, 4, destination register tag width.

Ports:
clk  in  1  clock; all state rising-edge.
rst_n  in  1  reset, asynchronous assert, active-low.
in_valid  in  1  upstream beat valid.
in_ready  out  1  stage can accept a beat.
in_data  in  DATA_W  ALU result.
in_carry  in  1  ALU carry (ARM convention: 1 = no borrow).
in_overflow  in  1  ALU signed overflow.
in_set_flags  in  1  beat updates NZCV.
in_dest  in  DEST_W  destination tag.
out_valid  out  1  downstream beat valid.
out_ready  in  1  downstream accepts.
out_data  out  DATA_W  registered result.
out_dest  out  DEST_W  registered tag.
flags_nzcv  out  4  architectural flags {N,Z,C,V}.
cond_code  in  4  condition to evaluate.
cond_pass  out  1  condition satisfied.

Behaviour:
- Reset (async, rst_n=0): buffer empty, out_valid=0, out_data=0, out_dest=0, flags_nzcv=4'b0000, in_ready=1 on the first edge after release. Reset mid-transfer discards both entries; no flag update from discarded beats.
- Accept = in_valid & in_ready; deliver = out_valid & out_ready.
- Skid buffer: 2 entries, count 0..2. in_ready = (count<2), registered (no combinational out_ready->in_ready path). out_valid = (count>0). Head entry drives out_data/out_dest directly from flops.
- Latency: accepted beat visible at output the next cycle when the buffer was empty; full throughput 1 beat/cycle with out_ready held high.
- Simultaneous accept+deliver: count unchanged; order preserved (FIFO). Accept at count=2 impossible (in_ready=0). Deliver at count=0 impossible.
- out_data/out_dest hold stable while out_valid & ~out_ready.
- Flags commit on accept (not on deliver) when in_set_flags=1: N=in_data[DATA_W-1], Z=(in_data==0), C=in_carry, V=in_overflow; visible on flags_nzcv the following cycle. No accept or in_set_flags=0: flags hold.
- cond_pass combinational from flags_nzcv: 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0.

Optional Feature:
ALU_FLAGS_BYPASS_EN. Defined: cond_pass evaluates against the flags being committed this cycle when accept & in_set_flags, else flags_nzcv (removes one bubble for compare-then-branch). Undefined: cond_pass uses flags_nzcv only; flags_nzcv timing identical in both builds.

Decomposition:
- Shared package: condition-code constants (COND_EQ..COND_NV), flag bit index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0), nzcv typedef.
- One natural sub-module: cond_eval (pure combinational nzcv + cond_code -> pass), reused by the issue stage.

Test Plan:
- Reset then beat in_data=2, C=1, V=0, set_flags=1, dest=3 -> next cycle out_valid=1, out_data=2, out_dest=3, flags_nzcv=0010; cond EQ->0, CS->1.
- in_data=0x7FFFFFFF, C=1, V=1, set_flags=1 -> flags 0011; VS->1, LT->1, GE->0, AL->1, NV->0.
- out_ready=0, three back-to-back beats -> two accepted, in_ready=0 at count=2, third held; release out_ready -> delivered in order, no loss or duplication.
- Beat in_data=0, set_flags=0 after flags=1000 -> flags remain 1000, data delivered normally.
- Assert rst_n=0 with count=2 -> out_valid=0, flags=0000 immediately; no stale beat after release.
- With ALU_FLAGS_BYPASS_EN: accept in_data=0, set_flags=1, cond EQ same cycle -> cond_pass=1; without macro -> 0 that cycle, 1 next.
